result_serializer: RTL

Downstream stage of the fixed/float conversion core. It accepts the 48-bit result words the core emits with a write strobe and buffers them in an internal word FIFO. It then serializes each word into a framed byte stream (sync byte plus 6 data bytes, MSB first) over a valid/ready byte interface toward the host transmit path. Because the conversion core has no backpressure input, overflow is detected, the word is dropped and the event is flagged.

---
 rtl/result_serializer.sv | 118 +++++++++++
 1 files changed

// File: rtl/result_serializer.sv
// Buffers 48-bit conversion results in a word FIFO and sends each one as a
// framed byte stream (SYNC header, then 6 data bytes MSB first) over valid/ready.
module result_serializer #(
  parameter int         DEPTH = 8,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [47:0]              din,
  input  logic                     wren,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [47:0]     r_mem [DEPTH];
  logic [47:0]     r_shift;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_byte_idx;
  logic            r_overflow;
  logic            w_pop;
  logic            w_push;
  logic            w_full;

  assign w_full = (r_count == FULL_CNT);
  // A full FIFO can still take a word on the same edge the head is popped.
  assign w_push = wren && (!w_full || w_pop);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = HDR;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = SYNC;
        if (tx_ready) w_state_next = DATA;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = r_shift[47:40];
        if (tx_ready && (r_byte_idx == 3'd5)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Storage carries no reset; pointer/count reset is what discards contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (wren && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift    <= '0;
      r_byte_idx <= '0;
    end else if (w_pop) begin
      r_shift    <= r_mem[r_rd_ptr];
      r_byte_idx <= '0;
    end else if ((r_state == HDR) && tx_ready) begin
      r_byte_idx <= '0;
    end else if ((r_state == DATA) && tx_ready) begin
      r_shift    <= {r_shift[39:0], 8'h00};
      r_byte_idx <= r_byte_idx + 3'd1;
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;
  assign busy     = (r_state != IDLE) || (r_count != '0);

endmodule
